pong_game_ctrl: RTL and testbench

//  Parametrised Pong game engine: ball/paddle state, score keeping and match FSM (SERVE/PLAY/SCORE/GAMEOVER).

---
 rtl/pong_pkg.sv | 20 ++
 rtl/pong_paddle.sv | 46 ++++
 rtl/pong_game_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and width helpers for the Pong game engine.
//   pong_state_e : match FSM encoding (SERVE=0, PLAY=1, SCORE=2, GAMEOVER=3)
//   coord_w()    : bits needed to hold a cell index 0..cells-1
package pong_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    SERVE    = 2'd0,
    PLAY     = 2'd1,
    SCORE    = 2'd2,
    GAMEOVER = 2'd3
  } pong_state_e;

  // Index width for a field dimension; never narrower than one bit.
  function automatic int unsigned coord_w(input int unsigned cells);
    return (cells > 1) ? $clog2(cells) : 1;
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: TICK-gated up/down position register clamped to 0..H-PAD.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   tick         game-step strobe
//   en           movement allowed this step
//   centre       reload the centred position on this step (has priority)
//   up, dn       movement requests; both or neither holds
//   pos          top row of the paddle
module pong_paddle
  import pong_pkg::*;
#(
  parameter  int unsigned H   = 15,
  parameter  int unsigned PAD = 4,
  localparam int unsigned YW  = coord_w(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          en,
  input  logic          centre,
  input  logic          up,
  input  logic          dn,
  output logic [YW-1:0] pos
);

  localparam logic [YW-1:0] POS_CTR = YW'((H - PAD) / 2);
  localparam logic [YW-1:0] POS_MAX = YW'(H - PAD);

  // Position register; single-direction requests only, clamped at both ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= POS_CTR;
    end else if (tick) begin
      if (centre) begin
        pos <= POS_CTR;
      end else if (en) begin
        if (up && !dn && (pos != '0)) begin
          pos <= pos - YW'(1);
        end else if (dn && !up && (pos < POS_MAX)) begin
          pos <= pos + YW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game engine: ball motion, paddle hits, score keeping and the match FSM
// (SERVE/PLAY/SCORE/GAMEOVER). One game step per TICK strobe.
// Ports:
//   GAME_CLK, RST        clock, asynchronous active-high reset
//   TICK                 game-step strobe
//   SERVE_BTN            serve / restart request (level, sampled on TICK)
//   PLAYER_BTN, COM_BTN  {up,dn} paddle buttons
//   ball_x_out/ball_y_out, player_pos_out, com_pos_out   object coordinates
//   score_player, score_com, state_out, point_pulse      score display / status
// Build option: COM_AI_EN -- com paddle follows the ball and COM_BTN is ignored.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter  int unsigned W         = 20,
  parameter  int unsigned H         = 15,
  parameter  int unsigned PAD       = 4,
  parameter  int unsigned WIN_SCORE = 5,
  parameter  int unsigned SW        = 4,
  localparam int unsigned XW        = coord_w(W),
  localparam int unsigned YW        = coord_w(H)
) (
  input  logic               GAME_CLK,
  input  logic               RST,
  input  logic               TICK,
  input  logic               SERVE_BTN,
  input  logic [1:0]         PLAYER_BTN,
  input  logic [1:0]         COM_BTN,
  output logic [XW-1:0]      ball_x_out,
  output logic [YW-1:0]      ball_y_out,
  output logic [YW-1:0]      player_pos_out,
  output logic [YW-1:0]      com_pos_out,
  output logic [SW-1:0]      score_player,
  output logic [SW-1:0]      score_com,
  output logic [STATE_W-1:0] state_out,
  output logic               point_pulse
);

  localparam logic [XW-1:0] X_CTR      = XW'(W / 2);
  localparam logic [YW-1:0] Y_CTR      = YW'(H / 2);
  localparam logic [XW-1:0] X_PLAYER   = XW'(1);      // column in front of player paddle
  localparam logic [XW-1:0] X_PL_BACK  = XW'(2);
  localparam logic [XW-1:0] X_COM      = XW'(W - 2);  // column in front of com paddle
  localparam logic [XW-1:0] X_COM_BACK = XW'(W - 3);
  localparam logic [XW-1:0] X_LAST     = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(H - 1);
  localparam logic [YW:0]   PAD_SPAN   = (YW+1)'(PAD - 1);
  localparam logic [SW-1:0] WIN_VAL    = SW'(WIN_SCORE);

  pong_state_e   state, state_nx;
  logic [XW-1:0] ball_x, ball_x_nx;
  logic [YW-1:0] ball_y, ball_y_nx;
  logic          dir_x, dir_x_nx;   // 1: +1 (toward com), 0: -1
  logic          dir_y, dir_y_nx;   // 1: +1 (down),       0: -1
  logic [SW-1:0] score_p, score_p_nx;
  logic [SW-1:0] score_c, score_c_nx;
  logic          pulse_nx;

  logic [YW-1:0] player_pos, com_pos;
  logic          pad_en, pad_centre;
  logic          com_up, com_dn;

  logic          play_dy;
  logic [YW-1:0] play_ny;
  logic          hit_player, hit_com;

  // Paddles move in SERVE/PLAY and are re-centred on a restart from GAMEOVER.
  assign pad_en     = (state == SERVE) || (state == PLAY);
  assign pad_centre = (state == GAMEOVER) && SERVE_BTN;

`ifdef COM_AI_EN
  logic [YW:0] com_ctr;
  logic        com_btn_unused;

  // Step the com paddle centre row toward the ball row.
  assign com_ctr        = {1'b0, com_pos} + (YW+1)'(PAD / 2);
  assign com_up         = ({1'b0, ball_y} < com_ctr);
  assign com_dn         = ({1'b0, ball_y} > com_ctr);
  assign com_btn_unused = ^COM_BTN;
`else
  assign com_up = COM_BTN[1];
  assign com_dn = COM_BTN[0];
`endif

  pong_paddle #(.H(H), .PAD(PAD)) u_player_pad (
    .clk    (GAME_CLK),
    .rst    (RST),
    .tick   (TICK),
    .en     (pad_en),
    .centre (pad_centre),
    .up     (PLAYER_BTN[1]),
    .dn     (PLAYER_BTN[0]),
    .pos    (player_pos)
  );

  pong_paddle #(.H(H), .PAD(PAD)) u_com_pad (
    .clk    (GAME_CLK),
    .rst    (RST),
    .tick   (TICK),
    .en     (pad_en),
    .centre (pad_centre),
    .up     (com_up),
    .dn     (com_dn),
    .pos    (com_pos)
  );

  // Wall reflection happens first; the paddle test sees the reflected row.
  always_comb begin
    play_dy = dir_y;
    if ((ball_y == '0) && !dir_y) begin
      play_dy = 1'b1;
    end else if ((ball_y == Y_LAST) && dir_y) begin
      play_dy = 1'b0;
    end
    play_ny = play_dy ? (ball_y + YW'(1)) : (ball_y - YW'(1));
  end

  // Paddle coverage uses the positions held at the start of the step.
  assign hit_player = ({1'b0, play_ny} >= {1'b0, player_pos}) &&
                      ({1'b0, play_ny} <= ({1'b0, player_pos} + PAD_SPAN));
  assign hit_com    = ({1'b0, play_ny} >= {1'b0, com_pos}) &&
                      ({1'b0, play_ny} <= ({1'b0, com_pos} + PAD_SPAN));

  // State register.
  always_ff @(posedge GAME_CLK or posedge RST) begin
    if (RST) begin
      state <= SERVE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and next ball/score values.
  always_comb begin
    state_nx   = state;
    ball_x_nx  = ball_x;
    ball_y_nx  = ball_y;
    dir_x_nx   = dir_x;
    dir_y_nx   = dir_y;
    score_p_nx = score_p;
    score_c_nx = score_c;
    pulse_nx   = 1'b0;

    case (state)
      SERVE: begin
        if (TICK && SERVE_BTN) begin
          state_nx = PLAY;
        end
      end

      PLAY: begin
        if (TICK) begin
          ball_y_nx = play_ny;
          dir_y_nx  = play_dy;
          if ((ball_x == X_PLAYER) && !dir_x) begin
            if (hit_player) begin
              dir_x_nx  = 1'b1;
              ball_x_nx = X_PL_BACK;
            end else begin
              ball_x_nx = '0;
              state_nx  = SCORE;
            end
          end else if ((ball_x == X_COM) && dir_x) begin
            if (hit_com) begin
              dir_x_nx  = 1'b0;
              ball_x_nx = X_COM_BACK;
            end else begin
              ball_x_nx = X_LAST;
              state_nx  = SCORE;
            end
          end else begin
            ball_x_nx = dir_x ? (ball_x + XW'(1)) : (ball_x - XW'(1));
          end
        end
      end

      SCORE: begin
        // Next serve heads toward whoever just lost the point.
        if (TICK) begin
          pulse_nx  = 1'b1;
          ball_x_nx = X_CTR;
          ball_y_nx = Y_CTR;
          if (ball_x == '0) begin
            score_c_nx = score_c + SW'(1);
            dir_x_nx   = 1'b0;
            state_nx   = ((score_c + SW'(1)) == WIN_VAL) ? GAMEOVER : SERVE;
          end else begin
            score_p_nx = score_p + SW'(1);
            dir_x_nx   = 1'b1;
            state_nx   = ((score_p + SW'(1)) == WIN_VAL) ? GAMEOVER : SERVE;
          end
        end
      end

      GAMEOVER: begin
        if (TICK && SERVE_BTN) begin
          score_p_nx = '0;
          score_c_nx = '0;
          state_nx   = SERVE;
        end
      end

      default: begin
        state_nx = SERVE;
      end
    endcase
  end

  // Ball, direction, score and pulse registers.
  always_ff @(posedge GAME_CLK or posedge RST) begin
    if (RST) begin
      ball_x      <= X_CTR;
      ball_y      <= Y_CTR;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      score_p     <= '0;
      score_c     <= '0;
      point_pulse <= 1'b0;
    end else begin
      ball_x      <= ball_x_nx;
      ball_y      <= ball_y_nx;
      dir_x       <= dir_x_nx;
      dir_y       <= dir_y_nx;
      score_p     <= score_p_nx;
      score_c     <= score_c_nx;
      point_pulse <= pulse_nx;
    end
  end

  assign ball_x_out     = ball_x;
  assign ball_y_out     = ball_y;
  assign player_pos_out = player_pos;
  assign com_pos_out    = com_pos;
  assign score_player   = score_p;
  assign score_com      = score_c;
  assign state_out      = state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl with a behavioural game model.
// The driver applies one input vector per clock, steps the model and queues
// the expected outputs; a negedge monitor pops and compares them.
module tb_pong_game_ctrl;

  localparam int W   = 20;
  localparam int H   = 15;
  localparam int PAD = 4;
  localparam int WIN = 5;

  localparam int ST_SERVE = 0;
  localparam int ST_PLAY  = 1;
  localparam int ST_SCORE = 2;
  localparam int ST_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       serve_btn;
  logic [1:0] player_btn;
  logic [1:0] com_btn;
  logic [4:0] ball_x;
  logic [3:0] ball_y;
  logic [3:0] player_pos;
  logic [3:0] com_pos;
  logic [3:0] score_player;
  logic [3:0] score_com;
  logic [1:0] state;
  logic       point_pulse;

  pong_game_ctrl #(
    .W(W), .H(H), .PAD(PAD), .WIN_SCORE(WIN), .SW(4)
  ) dut (
    .GAME_CLK       (clk),
    .RST            (rst),
    .TICK           (tick),
    .SERVE_BTN      (serve_btn),
    .PLAYER_BTN     (player_btn),
    .COM_BTN        (com_btn),
    .ball_x_out     (ball_x),
    .ball_y_out     (ball_y),
    .player_pos_out (player_pos),
    .com_pos_out    (com_pos),
    .score_player   (score_player),
    .score_com      (score_com),
    .state_out      (state),
    .point_pulse    (point_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int bx; int by; int pp; int cp; int sp; int sc; int st; int pulse;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Game model: plain integers, directions as +1/-1.
  int m_bx, m_by, m_dx, m_dy, m_pp, m_cp, m_sp, m_sc, m_st, m_pulse;

  function automatic void model_reset();
    m_bx = W / 2;  m_by = H / 2;
    m_dx = 1;      m_dy = 1;
    m_pp = (H - PAD) / 2;
    m_cp = (H - PAD) / 2;
    m_sp = 0;      m_sc = 0;
    m_st = ST_SERVE;
    m_pulse = 0;
  endfunction

  function automatic int pad_move(int pos, logic [1:0] btn);
    if (btn == 2'b10 && pos > 0)       return pos - 1;
    if (btn == 2'b01 && pos < H - PAD) return pos + 1;
    return pos;
  endfunction

`ifdef COM_AI_EN
  function automatic int ai_move(int pos, int by);
    int c;
    c = pos + PAD / 2;
    if (by < c && pos > 0)       return pos - 1;
    if (by > c && pos < H - PAD) return pos + 1;
    return pos;
  endfunction
`endif

  function automatic void model_step(bit t, bit srv, logic [1:0] pb, logic [1:0] cb);
    int opp, ocp, ny;
    m_pulse = 0;
    if (!t) return;
    opp = m_pp;
    ocp = m_cp;
    if (m_st == ST_SERVE || m_st == ST_PLAY) begin
      m_pp = pad_move(m_pp, pb);
`ifdef COM_AI_EN
      m_cp = ai_move(ocp, m_by);
`else
      m_cp = pad_move(m_cp, cb);
`endif
    end
    case (m_st)
      ST_SERVE: if (srv) m_st = ST_PLAY;
      ST_PLAY: begin
        if ((m_by == 0 && m_dy < 0) || (m_by == H - 1 && m_dy > 0)) m_dy = -m_dy;
        ny = m_by + m_dy;
        if (m_bx == 1 && m_dx < 0) begin
          if (ny >= opp && ny <= opp + PAD - 1) begin m_dx = 1; m_bx = 2; end
          else begin m_bx = 0; m_st = ST_SCORE; end
        end else if (m_bx == W - 2 && m_dx > 0) begin
          if (ny >= ocp && ny <= ocp + PAD - 1) begin m_dx = -1; m_bx = W - 3; end
          else begin m_bx = W - 1; m_st = ST_SCORE; end
        end else begin
          m_bx = m_bx + m_dx;
        end
        m_by = ny;
      end
      ST_SCORE: begin
        if (m_bx == 0) begin m_sc = m_sc + 1; m_dx = -1; end
        else begin m_sp = m_sp + 1; m_dx = 1; end
        m_pulse = 1;
        m_bx = W / 2;
        m_by = H / 2;
        m_st = (m_sc == WIN || m_sp == WIN) ? ST_OVER : ST_SERVE;
      end
      default: begin
        if (srv) begin
          m_sp = 0; m_sc = 0;
          m_pp = (H - PAD) / 2;
          m_cp = (H - PAD) / 2;
          m_st = ST_SERVE;
        end
      end
    endcase
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.bx = m_bx; e.by = m_by; e.pp = m_pp; e.cp = m_cp;
    e.sp = m_sp; e.sc = m_sc; e.st = m_st; e.pulse = m_pulse;
    return e;
  endfunction

  // Button pattern that steers the com paddle centre toward the model ball.
  function automatic logic [1:0] track_cb();
    int c;
    c = m_cp + PAD / 2;
    if (m_by < c) return 2'b10;
    if (m_by > c) return 2'b01;
    return 2'b00;
  endfunction

  task automatic compare_all(exp_t e, string tag);
    bit bad;
    bad = (int'(ball_x) != e.bx) || (int'(ball_y) != e.by) ||
          (int'(player_pos) != e.pp) || (int'(com_pos) != e.cp) ||
          (int'(score_player) != e.sp) || (int'(score_com) != e.sc) ||
          (int'(state) != e.st) || (int'(point_pulse) != e.pulse);
    n_vec++;
    if (bad) begin
      n_bad++;
      $display("FAIL %s @%0t: got ball=(%0d,%0d) pad=%0d/%0d score=%0d/%0d st=%0d pulse=%0d, exp ball=(%0d,%0d) pad=%0d/%0d score=%0d/%0d st=%0d pulse=%0d",
               tag, $time, ball_x, ball_y, player_pos, com_pos, score_player, score_com,
               state, point_pulse, e.bx, e.by, e.pp, e.cp, e.sp, e.sc, e.st, e.pulse);
    end
  endtask

  task automatic check_val(string name, int got, int expv);
    n_vec++;
    if (got != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, exp %0d", name, got, expv);
    end
  endtask

  // Monitor: one expected vector per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      compare_all(e, "step");
    end
  end

  // Apply one input vector across one rising edge; returns #1 after that edge.
  task automatic do_cycle(bit t, bit srv, logic [1:0] pb, logic [1:0] cb);
    @(negedge clk);
    #1;
    tick       = t;
    serve_btn  = srv;
    player_btn = pb;
    com_btn    = cb;
    @(posedge clk);
    model_step(t, srv, pb, cb);
    sbq.push_back(snap());
    #1;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #3;
    tick      = 1'b0;
    serve_btn = 1'b0;
    rst       = 1'b1;
    #1;
    model_reset();
    compare_all(snap(), "async_reset");
    check_val("async_reset_ball_x", int'(ball_x), 10);
    @(posedge clk);
    sbq.push_back(snap());
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout at %0t, exp completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; tick = 1'b0; serve_btn = 1'b0;
    player_btn = 2'b00; com_btn = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_ball_x", int'(ball_x), 10);
    check_val("rst_ball_y", int'(ball_y), 7);
    check_val("rst_player_pos", int'(player_pos), 5);
    check_val("rst_com_pos", int'(com_pos), 5);
    check_val("rst_score_player", int'(score_player), 0);
    check_val("rst_score_com", int'(score_com), 0);
    check_val("rst_state", int'(state), ST_SERVE);
    check_val("rst_pulse", int'(point_pulse), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Park com paddle at the top while waiting to serve.
    repeat (5) begin
      do_cycle(1'b1, 1'b0, 2'b00, 2'b10);
      do_cycle(1'b0, 1'b0, 2'b00, 2'b00);
    end
`ifndef COM_AI_EN
    check_val("com_parked", int'(com_pos), 0);
`endif
    do_cycle(1'b1, 1'b1, 2'b00, 2'b10);
    check_val("serve_state", int'(state), ST_PLAY);
    check_val("serve_ball_x", int'(ball_x), 10);
    repeat (8) begin
      do_cycle(1'b1, 1'b0, 2'b00, 2'b10);
      do_cycle(1'b0, 1'b0, 2'b00, 2'b00);
    end
`ifndef COM_AI_EN
    check_val("t8_ball_x", int'(ball_x), 18);
    check_val("t8_ball_y", int'(ball_y), 13);
    do_cycle(1'b1, 1'b0, 2'b00, 2'b10);
    check_val("t9_ball_x", int'(ball_x), 19);
    check_val("t9_state", int'(state), ST_SCORE);
    do_cycle(1'b1, 1'b0, 2'b00, 2'b10);
    check_val("t10_score_player", int'(score_player), 1);
    check_val("t10_pulse", int'(point_pulse), 1);
    check_val("t10_ball_x", int'(ball_x), 10);
    check_val("t10_ball_y", int'(ball_y), 7);
    check_val("t10_state", int'(state), ST_SERVE);
    do_cycle(1'b0, 1'b0, 2'b00, 2'b00);
    check_val("pulse_clear", int'(point_pulse), 0);
`endif

    // Paddle rules while in SERVE.
    do_cycle(1'b1, 1'b0, 2'b11, 2'b00);
    check_val("pad_both_hold", int'(player_pos), 5);
    do_cycle(1'b1, 1'b0, 2'b00, 2'b00);
    check_val("pad_none_hold", int'(player_pos), 5);
    repeat (20) do_cycle(1'b1, 1'b0, 2'b01, 2'b00);
    check_val("pad_dn_saturate", int'(player_pos), 11);
    do_cycle(1'b0, 1'b0, 2'b10, 2'b10);
    check_val("tick0_hold", int'(player_pos), 11);

`ifndef COM_AI_EN
    // Com paddle at 0 returns the serve: wall bounce at y=0 then hit at row 2.
    if (m_st == ST_SERVE && m_dx > 0 && m_dy < 0 && m_cp == 0) begin
      do_cycle(1'b1, 1'b1, 2'b00, 2'b00);
      repeat (9) do_cycle(1'b1, 1'b0, 2'b00, 2'b00);
      check_val("com_hit_ball_x", int'(ball_x), 17);
      check_val("com_hit_ball_y", int'(ball_y), 2);
      check_val("com_hit_state", int'(state), ST_PLAY);
      do_cycle(1'b1, 1'b0, 2'b00, 2'b00);
      check_val("com_hit_return_x", int'(ball_x), 16);
    end else begin
      n_vec++; n_bad++;
      $display("FAIL com_hit_setup: got st=%0d dx=%0d dy=%0d cp=%0d, exp st=0 dx=1 dy=-1 cp=0",
               m_st, m_dx, m_dy, m_cp);
    end
`endif

    // Randomised play; com tracks the ball most of the time.
    repeat (3000) begin
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2'($urandom),
               ($urandom_range(0, 9) < 7) ? track_cb() : 2'($urandom));
    end

    // Play on to a finished match.
    guard = 0;
    while (m_st != ST_OVER && guard < 20000) begin
      do_cycle(1'($urandom_range(0, 1)), 1'b1, 2'($urandom), track_cb());
      guard++;
    end
    if (m_st != ST_OVER) begin
      n_vec++; n_bad++;
      $display("FAIL gameover_reach: got state %0d, exp %0d", m_st, ST_OVER);
    end
    check_val("over_state", int'(state), ST_OVER);
    check_val("over_win_score",
              (score_com > score_player) ? int'(score_com) : int'(score_player), WIN);
    repeat (6) do_cycle(1'b1, 1'b0, 2'($urandom), 2'($urandom));
    check_val("over_frozen_state", int'(state), ST_OVER);
    do_cycle(1'b1, 1'b1, 2'b10, 2'b01);
    check_val("restart_score_player", int'(score_player), 0);
    check_val("restart_score_com", int'(score_com), 0);
    check_val("restart_player_pos", int'(player_pos), 5);
    check_val("restart_com_pos", int'(com_pos), 5);
    check_val("restart_state", int'(state), ST_SERVE);

    // Asynchronous reset in the middle of a rally.
    do_cycle(1'b1, 1'b1, 2'b00, 2'b00);
    repeat (3) do_cycle(1'b1, 1'b0, 2'($urandom), track_cb());
    check_val("pre_reset_state", int'(state), ST_PLAY);
    reset_mid();

    repeat (400) begin
      do_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 2'($urandom), track_cb());
    end

    repeat (3) @(negedge clk);
    #1;
    check_val("scoreboard_drained", sbq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
